// File: rtl/seq_mult_gen.sv
// Iterative signed/unsigned multiplier retiring BITS_PER_CYCLE multiplier bits per clock.
// Latency: operands accepted at edge T, dst_valid rises after edge T+STEPS; one result per STEPS+2 cycles.
// Backpressure: src_ready is low outside IDLE; the product is held in DONE until dst_ready, for as long as needed.
module seq_mult_gen #(
    parameter int WIDTH          = 16,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 src_valid,
    output logic                 src_ready,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    input  logic                 a_signed,
    input  logic                 b_signed,
    output logic                 dst_valid,
    input  logic                 dst_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);

    // Number of CALC cycles needed to walk every multiplier bit.
    localparam int STEPS = WIDTH / BITS_PER_CYCLE;
    // All accumulation is done modulo 2^(2*WIDTH): only the low 2*WIDTH bits
    // of the exact product are returned, so wider intermediates buy nothing.
    localparam int PW    = 2 * WIDTH;
    localparam int CW    = $clog2(STEPS + 1);
    localparam logic [CW-1:0] LAST_STEP = CW'(STEPS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          next_state;

    // Datapath state.
    // mcand_sh : extended multiplicand, pre-shifted to the weight of the
    //            multiplier bits currently sitting in mult_sh[BITS_PER_CYCLE-1:0].
    // mult_sh  : multiplier, shifted right as its bits are consumed.
    // b_sgn    : captured signedness of the multiplier; decides the weight of
    //            its top bit (negative for two's complement).
    logic [CW-1:0]   count;
    logic [PW-1:0]   acc;
    logic [PW-1:0]   mcand_sh;
    logic [WIDTH-1:0] mult_sh;
    logic            b_sgn;

    // Combinational helpers.
    logic [PW-1:0]   mcand_ext;
    logic [PW-1:0]   pp;
    logic [PW-1:0]   acc_sum;
    logic            in_idle;
    logic            in_calc;
    logic            last_step;
    logic            accept;
    logic            calc_adv;
    logic            finish;

    assign in_idle   = (state == S_IDLE);
    assign in_calc   = (state == S_CALC);
    assign last_step = (count == LAST_STEP);

    // A capture needs IDLE, a valid pair and no flush this cycle; flush wins.
    assign accept    = in_idle && src_valid && !flush;
    // One digit of the multiplier is retired on every CALC cycle not aborted.
    assign calc_adv  = in_calc && !flush;
    // The final digit's sum becomes the product.
    assign finish    = calc_adv && last_step;

    // The multiplicand is widened once at capture: sign-extended when signed,
    // zero-extended otherwise.  Extending straight to 2*WIDTH is equivalent to
    // the WIDTH+1 extension followed by truncation of the product.
    assign mcand_ext = {{WIDTH{a_signed & multiplicand[WIDTH-1]}}, multiplicand};

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: flush returns to IDLE from anywhere.
    always_comb begin
        next_state = state;
        unique case (state)
            S_IDLE: begin
                if (flush) begin
                    next_state = S_IDLE;
                end else if (src_valid) begin
                    next_state = S_CALC;
                end
            end
            S_CALC: begin
                if (flush) begin
                    next_state = S_IDLE;
                end else if (last_step) begin
                    next_state = S_DONE;
                end
            end
            S_DONE: begin
                if (flush || dst_ready) begin
                    next_state = S_IDLE;
                end
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    // State-decoded outputs; src_ready is forced low while reset is held.
    always_comb begin
        src_ready = 1'b0;
        busy      = 1'b0;
        unique case (state)
            S_IDLE:  src_ready = !rst;
            S_CALC:  busy      = 1'b1;
            S_DONE:  busy      = 1'b1;
            default: begin
                src_ready = 1'b0;
                busy      = 1'b0;
            end
        endcase
    end

    // dst_valid comes straight from a flop so consumers see a clean signal.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dst_valid <= 1'b0;
        end else begin
            dst_valid <= (next_state == S_DONE);
        end
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------

    // Partial product for the current digit.  Every multiplier bit carries
    // weight +2^i except the very top bit of a signed multiplier, which
    // carries -2^(WIDTH-1); that bit is only seen in the last step, in the
    // highest lane.  An unsigned multiplier's top bit stays positive, which
    // is exactly the zero-extended WIDTH+1-bit interpretation.
    always_comb begin
        pp = '0;
        for (int j = 0; j < BITS_PER_CYCLE; j++) begin
            if (mult_sh[j]) begin
                if (last_step && (j == BITS_PER_CYCLE - 1) && b_sgn) begin
                    pp = pp - (mcand_sh << j);
                end else begin
                    pp = pp + (mcand_sh << j);
                end
            end
        end
    end

    assign acc_sum = acc + pp;

    // Operand capture and per-step shift/accumulate.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc      <= '0;
            mcand_sh <= '0;
            mult_sh  <= '0;
            b_sgn    <= 1'b0;
            count    <= '0;
        end else if (accept) begin
            acc      <= '0;
            mcand_sh <= mcand_ext;
            mult_sh  <= multiplier;
            b_sgn    <= b_signed;
            count    <= '0;
        end else if (calc_adv) begin
            acc      <= acc_sum;
            mcand_sh <= mcand_sh << BITS_PER_CYCLE;
            mult_sh  <= mult_sh >> BITS_PER_CYCLE;
            count    <= count + 1'b1;
        end
    end

    // Result register: loaded on the last CALC step and held through DONE,
    // so it stays stable however long the consumer stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            product <= '0;
        end else if (finish) begin
            product <= acc_sum;
        end
    end

endmodule

// File: doc/seq_mult_gen.md
# seq_mult_gen

Parametrised iterative multiplier. Each operand can be signed or unsigned, chosen per operation. It retires `BITS_PER_CYCLE` multiplier bits per clock and uses valid/ready handshakes on both the operand side and the product side. It is the next-generation replacement for the fixed 16-bit start/ready sequential multiplier, and sits between a producer that issues operand pairs and a consumer that may stall on results.

## Interface
- `WIDTH`, 16: operand width. Must be ≥ 4 and divisible by `BITS_PER_CYCLE`.
- `BITS_PER_CYCLE`, 1: multiplier bits retired per CALC cycle; legal values 1 or 2.
- `STEPS` (localparam) = `WIDTH/BITS_PER_CYCLE`.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `flush`, in, 1: synchronous abort of any operation in flight.
- `src_valid`, in, 1: operand pair and mode valid.
- `src_ready`, out, 1: block can accept operands.
- `multiplicand`, in, `WIDTH`: operand A.
- `multiplier`, in, `WIDTH`: operand B.
- `a_signed`, in, 1: 1 = A is two's complement, 0 = A is unsigned.
- `b_signed`, in, 1: 1 = B is two's complement, 0 = B is unsigned.
- `dst_valid`, out, 1: `product` valid.
- `dst_ready`, in, 1: consumer accepts the product.
- `product`, out, `2*WIDTH`: result. Two's complement if either operand is signed, else unsigned.
- `busy`, out, 1: high in CALC or DONE.

## Operation
- FSM has three states: IDLE, CALC, DONE. Reset state is IDLE.
- IDLE:
  - `src_ready`=1.
  - On `src_valid && src_ready`, register `multiplicand`, `multiplier`, `a_signed`, `b_signed`; clear the step counter and the accumulator; go to CALC.
- CALC:
  - Each cycle consumes `BITS_PER_CYCLE` multiplier bits, LSB first, and increments the counter.
  - After `STEPS` cycles, `product` is registered and the FSM goes to DONE.
  - Inputs are ignored; `src_ready`=0.
- DONE:
  - `dst_valid`=1 and `product` is held stable until `dst_valid && dst_ready`.
  - On that handshake, go to IDLE.
  - Backpressure duration is unbounded.
- Arithmetic:
  - Each operand is extended to `WIDTH+1` bits: sign-extended if its signed flag is 1, zero-extended if 0.
  - `product` = low `2*WIDTH` bits of the exact product of the extended operands. Every mode combination fits without overflow.
  - Radix-2 Booth or radix-4 Booth (for `BITS_PER_CYCLE`=2) are acceptable internal algorithms, provided the cycle counts below hold exactly.
- `flush` (any state): next state is IDLE, `dst_valid` goes to 0, and the result in flight is discarded. In IDLE, `flush` has priority over `src_valid`: no capture occurs that cycle.
- Operand inputs may change freely after the accepting edge; the result depends only on the captured values.

## Timing
- Reset values:
  - `src_ready`=1 while `rst` is low; `src_ready`=0 while `rst` is asserted.
  - `dst_valid`=0, `busy`=0, `product`=0, FSM=IDLE, counter=0.
- Latency: operands accepted at edge T → `dst_valid` rises after edge T+`STEPS`.
  - `WIDTH`=16, `BITS_PER_CYCLE`=1: 16 cycles.
  - `WIDTH`=16, `BITS_PER_CYCLE`=2: 8 cycles.
- Throughput: with `dst_ready` held high and `src_valid` held high, one result every `STEPS`+2 cycles (CALC ×`STEPS`, DONE ×1, IDLE ×1).
- `src_ready` depends only on state, never combinationally on `src_valid`. `dst_valid` is registered.
- `rst` asserted mid-CALC or mid-DONE: outputs take reset values immediately (asynchronously), and the operation is lost.
- `dst_ready` high while `dst_valid`=0: no effect.

## Test plan
1. **Reset:** assert `rst` mid-CALC for 2 cycles, then deassert → `dst_valid`=0, `busy`=0, `product`=0 immediately; `src_ready`=1 from the first edge after deassertion.
2. **Signed corners, `WIDTH`=16, `BITS_PER_CYCLE`=1:**
   - −32768×−32768 → 1073741824.
   - 32767×−32768 → −1073709056.
   - −1×−1 → 1.
   - 0×−32768 → 0.
   - In every case `dst_valid` rises exactly 16 cycles after acceptance.
3. **Mixed/unsigned modes:**
   - A=0xFFFF, B=0xFFFF, both unsigned → 0xFFFE0001.
   - A signed (−1), B unsigned (65535) → −65535 (0xFFFF0001).
   - A unsigned (65535), B signed (−2) → −131070.
4. **Backpressure:** hold `dst_ready`=0 for 20 cycles after `dst_valid` rises →
   - `product` stable throughout.
   - `src_ready`=0 throughout.
   - `src_valid` pulses are ignored.
   - After `dst_ready`=1 for one edge: `dst_valid`=0 and `src_ready`=1.
5. **Flush and priority:**
   - `flush` at CALC step 5 → IDLE next cycle with no `dst_valid`; the next operation, 7×9, returns 63.
   - `flush` and `src_valid` together in IDLE → no capture.
6. **Radix-4 build and throughput:**
   - Build `BITS_PER_CYCLE`=2 and run 100k random pairs with random mode bits against a behavioural `$signed`/`$unsigned` model: zero mismatches, latency exactly 8 cycles.
   - Back-to-back operation with `dst_ready`=1: one result every 10 cycles.
